palette_lookup_arbiter: RTL and testbench
=========================================

Name: palette_lookup_arbiter

Overview:
- Shares the single 16-entry tile palette ROM between up to N_REQ pixel renderers (tank sprites, bullets, playfield tiles).
- Each cycle it selects one pending lookup round-robin and drives the ROM index.
- It registers the returned 12-bit RGB with the requester ID and a transparency flag, and presents the result on a valid/ready response channel to the pixel compositor.
- It sits between the renderers and the VGA compositor; the ROM itself stays combinational and external.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must equal clog2(N_REQ).
- IDX_W, 4, palette index width (16 entries).
- TRANSP_IDX, 0, palette index treated as transparent.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester lookup request.
- req_index  in  N_REQ*IDX_W  per-requester palette index; requester i occupies bits [i*IDX_W +: IDX_W].
- req_ready  out  N_REQ  one-hot (or zero) acceptance of a request this cycle.
- pal_index  out  IDX_W  index driven to the shared palette ROM.
- pal_rgb  in  12  ROM output {red, green, blue}, combinational from pal_index.
- rsp_valid  out  1  response holds a result.
- rsp_ready  in  1  compositor accepts the response.
- rsp_id  out  ID_W  requester that owns the response.
- rsp_red, rsp_green, rsp_blue  out  4 each  looked-up colour.
- rsp_transparent  out  1  looked-up index == TRANSP_IDX.

Behaviour:
- Reset (async on Reset_n low, released synchronously to Clk):
  - rsp_valid=0, rsp_id=0, rsp colours=0, rsp_transparent=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has first priority.
- Accept condition: accept = !rsp_valid || rsp_ready. Single output register, no skid buffer, so full throughput is one lookup per cycle.
- Arbitration (combinational):
  - Scan requesters starting at last_grant+1 (mod N_REQ), wrapping around.
  - The first with req_valid=1 is the grant.
  - No valid requests: no grant.
- req_ready[g] = accept && grant_valid; all other bits are 0. req_ready never asserts for a requester with req_valid=0.
- pal_index:
  - Equals req_index of the granted requester.
  - Equals 0 when there is no grant.
  - Holds that value throughout the cycle; pal_rgb is sampled the same cycle.
- Transfer (rising edge with accept && grant_valid):
  - rsp_valid<=1, rsp_id<=g.
  - {rsp_red, rsp_green, rsp_blue}<=pal_rgb.
  - rsp_transparent<=(pal_index==TRANSP_IDX).
  - last_grant<=g.
- Latency: one cycle from request handshake to rsp_valid.
- Drain: rsp_ready=1 with no grant -> rsp_valid<=0. Data fields hold their last values.
- Stall: rsp_valid=1 && rsp_ready=0:
  - No grants, all req_ready=0, last_grant frozen.
  - All rsp_* fields hold bit-stable.
- Simultaneous drain and new grant (rsp_valid=1, rsp_ready=1, grant): the response is replaced back-to-back; rsp_valid stays 1.
- Requester protocol: req_valid and req_index must stay stable until req_ready. The block does not latch unaccepted requests.
- Fairness: a continuously valid requester is granted within N_REQ accepting cycles.
- Reset mid-stall: the pending response is discarded; the outputs and last_grant take the reset values above.

Decomposition:
- Shared package palette_pkg:
  - IDX_W, COLOR_W=4, RGB_W=12.
  - Typedef rgb_t as a struct of red, green and blue, 4 bits each.
  - TRANSP_IDX default.
- One sub-module, rr_arbiter: parameter N; inputs req[N], last[ID_W]; outputs grant_valid, grant_id. Purely combinational rotate-priority picker.
- The top holds the accept logic, the output register and the last_grant register.

Test Plan:
- Single requester: req_valid[2]=1, index 5, rsp_ready=1, pal_rgb=0x0F0 -> req_ready=0b0100 in cycle 0; cycle 1 rsp_valid=1, rsp_id=2, rgb=0,F,0, rsp_transparent=0.
- All four requesters valid, rsp_ready=1 for 8 cycles after reset -> grants in order 0,1,2,3,0,1,2,3; rsp_valid stays 1 every cycle after the first.
- Backpressure: rsp_ready=0 for 3 cycles with the response held -> req_ready=0 and rsp_* bit-stable; on rsp_ready=1 the next grant is last_grant+1.
- Transparency: index 0 -> rsp_transparent=1; index 1 -> rsp_transparent=0; rgb is still passed through in both cases.
- Reset_n pulsed low mid-cycle while rsp_valid=1 and stalled -> rsp_valid=0 immediately (async); the first post-reset grant goes to requester 0 when all requesters are valid.
- Idle drain: one request then none, rsp_ready=1 -> rsp_valid=1 for exactly one cycle, then 0; pal_index=0 while idle.

Source files
------------

// File: rtl/palette_pkg.sv
// rtl/palette_pkg.sv - shared widths, colour type and transparency index for the palette arbiter
package palette_pkg;

    localparam int IDX_W      = 4;
    localparam int COLOR_W    = 4;
    localparam int RGB_W      = 3 * COLOR_W;
    localparam int TRANSP_IDX = 0;

    typedef struct packed {
        logic [COLOR_W-1:0] red;
        logic [COLOR_W-1:0] green;
        logic [COLOR_W-1:0] blue;
    } rgb_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority picker starting after the last grant
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id
);

    int cand;

    // Offsets 1..N from last, so the previous winner is considered last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// rtl/palette_lookup_arbiter.sv - round-robin sharing of the palette ROM with a registered response
module palette_lookup_arbiter
    import palette_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int IDX_W      = palette_pkg::IDX_W,
    parameter int TRANSP_IDX = palette_pkg::TRANSP_IDX
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*IDX_W-1:0] req_index,
    output logic [N_REQ-1:0]       req_ready,
    output logic [IDX_W-1:0]       pal_index,
    input  logic [RGB_W-1:0]       pal_rgb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [COLOR_W-1:0]     rsp_red,
    output logic [COLOR_W-1:0]     rsp_green,
    output logic [COLOR_W-1:0]     rsp_blue,
    output logic                   rsp_transparent
);

    logic            accept;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] last_grant;
    rgb_t            rsp_rgb;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last        (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Single output register: a new result may land only if the old one leaves this cycle.
    assign accept = !rsp_valid || rsp_ready;

    always_comb begin
        req_ready = '0;
        pal_index = '0;
        if (grant_valid) begin
            pal_index = req_index[int'(grant_id)*IDX_W +: IDX_W];
        end
        if (accept && grant_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_rgb         <= '0;
            rsp_transparent <= 1'b0;
            last_grant      <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            if (grant_valid) begin
                rsp_valid       <= 1'b1;
                rsp_id          <= grant_id;
                rsp_rgb         <= pal_rgb;
                rsp_transparent <= (pal_index == IDX_W'(TRANSP_IDX));
                last_grant      <= grant_id;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_red   = rsp_rgb.red;
    assign rsp_green = rsp_rgb.green;
    assign rsp_blue  = rsp_rgb.blue;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// tb/tb_palette_lookup_arbiter.sv - directed self-checking bench for palette_lookup_arbiter
module tb_palette_lookup_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_index;
    logic [3:0]  req_ready;
    logic [3:0]  pal_index;
    logic [11:0] pal_rgb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_red;
    logic [3:0]  rsp_green;
    logic [3:0]  rsp_blue;
    logic        rsp_transparent;

    logic [11:0] rom [16];
    int          n_checks;
    int          n_pass;

    palette_lookup_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_index       (req_index),
        .req_ready       (req_ready),
        .pal_index       (pal_index),
        .pal_rgb         (pal_rgb),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_id          (rsp_id),
        .rsp_red         (rsp_red),
        .rsp_green       (rsp_green),
        .rsp_blue        (rsp_blue),
        .rsp_transparent (rsp_transparent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign pal_rgb = rom[pal_index];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] rsp_rgb_now();
        return {rsp_red, rsp_green, rsp_blue};
    endfunction

    logic [11:0] held_rgb;
    logic [1:0]  held_id;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 16; i++) rom[i] = {4'(i), 4'hA, ~4'(i)};
        rom[5] = 12'h0F0;

        rst_n     = 1'b0;
        req_valid = '0;
        req_index = '0;
        rsp_ready = 1'b0;
        #12;
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset rsp_id", 32'(rsp_id), 0);
        check("reset rgb", 32'(rsp_rgb_now()), 0);
        check("reset transp", 32'(rsp_transparent), 0);
        check("reset pal_index", 32'(pal_index), 0);
        rst_n = 1'b1;
        step();

        // single requester 2, index 5
        req_valid = 4'b0100;
        req_index = 16'h0500;
        rsp_ready = 1'b1;
        #2;
        check("single req_ready", 32'(req_ready), 32'b0100);
        check("single pal_index", 32'(pal_index), 5);
        step();
        req_valid = '0;
        check("single rsp_valid", 32'(rsp_valid), 1);
        check("single rsp_id", 32'(rsp_id), 2);
        check("single rgb", 32'(rsp_rgb_now()), 32'h0F0);
        check("single transp", 32'(rsp_transparent), 0);
        #2;
        check("idle pal_index", 32'(pal_index), 0);
        check("idle req_ready", 32'(req_ready), 0);
        step();
        check("drain rsp_valid", 32'(rsp_valid), 0);
        check("drain id held", 32'(rsp_id), 2);
        check("drain rgb held", 32'(rsp_rgb_now()), 32'h0F0);

        // round robin from reset, indices 8..11
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req_valid = 4'b1111;
        req_index = 16'hBA98;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("rr%0d req_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
            check($sformatf("rr%0d pal_index", k), 32'(pal_index), 32'(8 + k % 4));
            step();
            check($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), 1);
            check($sformatf("rr%0d rsp_id", k), 32'(rsp_id), 32'(k % 4));
            check($sformatf("rr%0d rgb", k), 32'(rsp_rgb_now()), 32'(rom[8 + k % 4]));
        end

        // backpressure: response id 3 held for three cycles
        rsp_ready = 1'b0;
        held_id   = 2'd3;
        held_rgb  = rom[11];
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d req_ready", k), 32'(req_ready), 0);
            step();
            check($sformatf("stall%0d rsp_valid", k), 32'(rsp_valid), 1);
            check($sformatf("stall%0d rsp_id", k), 32'(rsp_id), 32'(held_id));
            check($sformatf("stall%0d rgb", k), 32'(rsp_rgb_now()), 32'(held_rgb));
        end
        rsp_ready = 1'b1;
        #1;
        check("resume req_ready", 32'(req_ready), 32'b0001);
        step();
        check("resume rsp_id", 32'(rsp_id), 0);

        // transparency on requester 1
        req_valid = 4'b0010;
        req_index = 16'h0000;
        #1;
        check("transp0 req_ready", 32'(req_ready), 32'b0010);
        step();
        check("transp0 flag", 32'(rsp_transparent), 1);
        check("transp0 rgb", 32'(rsp_rgb_now()), 32'(rom[0]));
        check("transp0 rsp_id", 32'(rsp_id), 1);
        req_index = 16'h0010;
        step();
        check("transp1 flag", 32'(rsp_transparent), 0);
        check("transp1 rgb", 32'(rsp_rgb_now()), 32'(rom[1]));

        // reset while stalled with a valid response
        req_valid = 4'b1111;
        req_index = 16'hBA98;
        step();
        check("pre-reset rsp_id", 32'(rsp_id), 2);
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async reset rsp_valid", 32'(rsp_valid), 0);
        check("async reset rsp_id", 32'(rsp_id), 0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("post-reset req_ready", 32'(req_ready), 32'b0001);
        step();
        check("post-reset rsp_id", 32'(rsp_id), 0);
        check("post-reset rsp_valid", 32'(rsp_valid), 1);
        req_valid = '0;
        step();
        check("final drain", 32'(rsp_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
